// File: rtl/elm_pkg.sv
// ----------------------------------------------------------------------------
// elm_pkg
// Shared definitions for the ELM output stage: the engine FSM state type, a
// clog2 helper used for address/index widths, and the default datapath widths
// shared with the argmax controller.
// ----------------------------------------------------------------------------
package elm_pkg;

    localparam int unsigned ELM_DW    = 16;  // activation / weight width
    localparam int unsigned ELM_AW    = 40;  // accumulator width
    localparam int unsigned ELM_OW    = 16;  // stored score width
    localparam int unsigned ELM_SHIFT = 8;   // fixed-point rescale shift

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StDrain,
        StStore,
        StDone
    } elm_state_e;

    // Never returns less than 1 so a single-entry dimension still gets a bit.
    function automatic int unsigned elm_clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/elm_output_layer_engine_if.sv
// ----------------------------------------------------------------------------
// elm_output_layer_engine_if
// Bundles the engine's control, memory-read and score-read signals.
//   start      : begin a computation
//   h_addr     : hidden activation RAM address   h_data : activation (1-cycle latency)
//   w_addr     : weight ROM address c*N_HIDDEN+j w_data : weight (1-cycle latency)
//   score_idx  : downstream read index           score  : buffer[score_idx]
//   m2_done    : scores complete and stable      busy   : computation in progress
// Modports: slave = engine, master = environment (memories + argmax side).
// ----------------------------------------------------------------------------
interface elm_output_layer_engine_if
    import elm_pkg::*;
#(
    parameter int unsigned N_HIDDEN = 64,
    parameter int unsigned N_CLASS  = 10,
    parameter int unsigned DW       = ELM_DW,
    parameter int unsigned OW       = ELM_OW
);
    localparam int unsigned HAW = elm_clog2(N_HIDDEN);
    localparam int unsigned WAW = elm_clog2(N_CLASS * N_HIDDEN);
    localparam int unsigned CW  = elm_clog2(N_CLASS);

    logic                 start;
    logic [HAW-1:0]       h_addr;
    logic signed [DW-1:0] h_data;
    logic [WAW-1:0]       w_addr;
    logic signed [DW-1:0] w_data;
    logic [CW-1:0]        score_idx;
    logic signed [OW-1:0] score;
    logic                 m2_done;
    logic                 busy;

    modport slave (
        input  start, h_data, w_data, score_idx,
        output h_addr, w_addr, score, m2_done, busy
    );

    modport master (
        output start, h_data, w_data, score_idx,
        input  h_addr, w_addr, score, m2_done, busy
    );

endinterface

// File: rtl/elm_mac.sv
// ----------------------------------------------------------------------------
// elm_mac
// Signed DW x DW multiply with AW-bit accumulate.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : add the current product this cycle
//   i_clr          : synchronous clear (wins over i_en)
//   i_a, i_b       : signed operands
//   o_acc          : signed accumulator
// ----------------------------------------------------------------------------
module elm_mac #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 40
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    output logic signed [AW-1:0] o_acc
);
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_prod_ext;
    logic signed [AW-1:0]   r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(AW - 2 * DW){w_prod[2*DW-1]}}, w_prod};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/elm_output_layer_engine.sv
// ----------------------------------------------------------------------------
// elm_output_layer_engine
// Computes score[c] = sum_j h[j]*w[c][j] for every class, stores the rescaled
// result in a score buffer, then raises m2_done and holds the buffer for the
// argmax stage until the next start.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   io_bus  : elm_output_layer_engine_if.slave (start, memory ports, score read,
//             m2_done, busy)
// Build option: ELM_SCORE_SAT_EN -- clamp the shifted accumulator to the OW
// range instead of keeping its low OW bits.
// ----------------------------------------------------------------------------
module elm_output_layer_engine
    import elm_pkg::*;
#(
    parameter int unsigned N_HIDDEN = 64,
    parameter int unsigned N_CLASS  = 10,
    parameter int unsigned DW       = ELM_DW,
    parameter int unsigned AW       = ELM_AW,
    parameter int unsigned SHIFT    = ELM_SHIFT,
    parameter int unsigned OW       = ELM_OW
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    elm_output_layer_engine_if.slave    io_bus
);
    localparam int unsigned HAW = elm_clog2(N_HIDDEN);
    localparam int unsigned WAW = elm_clog2(N_CLASS * N_HIDDEN);
    localparam int unsigned CW  = elm_clog2(N_CLASS);

    localparam logic [HAW-1:0] J_LAST = HAW'(N_HIDDEN - 1);
    localparam logic [CW-1:0]  C_LAST = CW'(N_CLASS - 1);
    localparam logic [WAW-1:0] W_STEP = WAW'(N_HIDDEN);

    elm_state_e           r_state, w_state_d;
    logic [HAW-1:0]       r_j, w_j_d;
    logic [CW-1:0]        r_c, w_c_d;
    logic [WAW-1:0]       r_wbase, w_wbase_d;
    logic                 r_busy, w_busy_d;
    logic                 r_done, w_done_d;
    logic                 r_mac_en;  // an address went out last cycle, its data is here now
    logic                 w_store;
    logic signed [AW-1:0] w_acc;
    logic signed [OW-1:0] w_result;
    logic signed [OW-1:0] r_buf [N_CLASS];

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_d = r_state;
        w_j_d     = r_j;
        w_c_d     = r_c;
        w_wbase_d = r_wbase;
        w_busy_d  = r_busy;
        w_done_d  = r_done;
        w_store   = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                // Flags settle one cycle after entering DONE.
                if (r_state == StDone) begin
                    w_done_d = 1'b1;
                    w_busy_d = 1'b0;
                end
                if (io_bus.start) begin
                    w_state_d = StAddr;
                    w_j_d     = '0;
                    w_c_d     = '0;
                    w_wbase_d = '0;
                    w_busy_d  = 1'b1;
                    w_done_d  = 1'b0;
                end
            end
            StAddr: begin
                if (r_j == J_LAST) begin
                    w_state_d = StDrain;
                end else begin
                    w_j_d = r_j + 1'b1;
                end
            end
            StDrain: begin
                w_state_d = StStore;
            end
            StStore: begin
                w_store = 1'b1;
                w_j_d   = '0;
                if (r_c == C_LAST) begin
                    w_state_d = StDone;
                end else begin
                    w_c_d     = r_c + 1'b1;
                    w_wbase_d = r_wbase + W_STEP;
                    w_state_d = StAddr;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_j      <= '0;
            r_c      <= '0;
            r_wbase  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mac_en <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_j      <= w_j_d;
            r_c      <= w_c_d;
            r_wbase  <= w_wbase_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_mac_en <= (r_state == StAddr);
        end
    end

    // ---------------------------------------------------------------- datapath
    elm_mac #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (r_mac_en),
        .i_clr   (w_store),
        .i_a     (io_bus.h_data),
        .i_b     (io_bus.w_data),
        .o_acc   (w_acc)
    );

`ifdef ELM_SCORE_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    logic signed [AW-1:0] w_shr;
    assign w_shr = w_acc >>> SHIFT;

    always_comb begin
        w_result = OW'(w_shr);
        if (w_shr > SAT_MAX) begin
            w_result = OW'(SAT_MAX);
        end else if (w_shr < SAT_MIN) begin
            w_result = OW'(SAT_MIN);
        end
    end
`else
    assign w_result = OW'(w_acc >>> SHIFT);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(N_CLASS); i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_store) begin
            r_buf[r_c] <= w_result;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign io_bus.h_addr  = r_j;
    assign io_bus.w_addr  = r_wbase + WAW'(r_j);
    assign io_bus.busy    = r_busy;
    assign io_bus.m2_done = r_done;
    assign io_bus.score   = (32'(io_bus.score_idx) < N_CLASS) ? r_buf[io_bus.score_idx] : '0;

endmodule

// File: tb/tb_elm_output_layer_engine.sv
// ----------------------------------------------------------------------------
// tb_elm_output_layer_engine
// Drives elm_output_layer_engine through its interface with modelled
// activation RAM / weight ROM contents (directed patterns and $urandom data)
// and compares timing, address sequence and scores against a plain
// arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_elm_output_layer_engine;
    import elm_pkg::*;

    localparam int NH      = 64;
    localparam int NC      = 10;
    localparam int LATENCY = NC * (NH + 2) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] hmem [NH];
    logic signed [15:0] wmem [NH*NC];
    longint             exp_score [NC];

    elm_output_layer_engine_if #(
        .N_HIDDEN (NH),
        .N_CLASS  (NC),
        .DW       (16),
        .OW       (16)
    ) ifc ();

    elm_output_layer_engine #(
        .N_HIDDEN (NH),
        .N_CLASS  (NC),
        .DW       (16),
        .AW       (40),
        .SHIFT    (8),
        .OW       (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (ifc)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        ifc.h_data <= hmem[ifc.h_addr];
        ifc.w_data <= wmem[ifc.w_addr];
    end

    task automatic check_eq(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: dot product, arithmetic shift, then wrap or clamp to 16 bits.
    function automatic longint ref_score(input int c);
        longint acc;
        longint sh;
        acc = 0;
        for (int j = 0; j < NH; j++) begin
            acc += longint'(hmem[j]) * longint'(wmem[c*NH + j]);
        end
        sh = acc >>> 8;
`ifdef ELM_SCORE_SAT_EN
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
        return sh;
`else
        return longint'(shortint'(sh));
`endif
    endfunction

    // 0 unity, 1 class ramp, 2 negative, otherwise random.
    task automatic fill(input int mode);
        for (int j = 0; j < NH; j++) begin
            case (mode)
                0:       hmem[j] = 16'sd1;
                1:       hmem[j] = 16'sd256;
                2:       hmem[j] = -16'sd1;
                default: hmem[j] = 16'($urandom);
            endcase
        end
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < NH; j++) begin
                case (mode)
                    0, 2:    wmem[c*NH + j] = 16'sd256;
                    1:       wmem[c*NH + j] = 16'(c * 256);
                    default: wmem[c*NH + j] = 16'($urandom);
                endcase
            end
            exp_score[c] = ref_score(c);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_h_addr"}, 64'(ifc.h_addr), 0);
        check_eq({tag, "_w_addr"}, 64'(ifc.w_addr), 0);
        check_eq({tag, "_m2_done"}, 64'(ifc.m2_done), 0);
        check_eq({tag, "_busy"}, 64'(ifc.busy), 0);
        for (int i = 0; i < NC; i++) begin
            ifc.score_idx = 4'(i);
            #1;
            check_eq($sformatf("%s_score%0d", tag, i), ifc.score, 0);
        end
    endtask

    task automatic read_scores(input string tag);
        for (int i = 0; i < 16; i++) begin
            ifc.score_idx = 4'(i);
            #1;
            check_eq($sformatf("%s_score%0d", tag, i), ifc.score,
                     (i < NC) ? exp_score[i] : 0);
        end
    endtask

    // Start pulse sampled by edge 0; edge n is sampled 1 time unit after it.
    task automatic run_case(input string tag, input bit repulse, input int rst_at);
        int done_at;
        int addr_err;
        done_at  = -1;
        addr_err = 0;
        @(posedge clk);
        #1;
        ifc.start = 1'b1;
        for (int n = 0; n < LATENCY + 200 && done_at < 0; n++) begin
            @(posedge clk);
            #1;
            ifc.start = repulse && (n == 49 || n == 299);
            if (n == 0) begin
                check_eq({tag, "_busy_rise"}, 64'(ifc.busy), 1);
                check_eq({tag, "_done_clear"}, 64'(ifc.m2_done), 0);
            end
            if (n < NC * (NH + 2) && (n % (NH + 2)) < NH) begin
                if (int'(ifc.h_addr) != n % (NH + 2) ||
                    int'(ifc.w_addr) != (n / (NH + 2)) * NH + n % (NH + 2)) begin
                    addr_err++;
                end
            end
            if (n == LATENCY - 1) begin
                check_eq({tag, "_busy_pre"}, 64'(ifc.busy), 1);
                check_eq({tag, "_done_pre"}, 64'(ifc.m2_done), 0);
            end
            if (rst_at > 0 && n == rst_at - 1) begin
                check_eq({tag, "_addr_sweep"}, addr_err, 0);
                rst_n = 1'b0;
                #1;
                check_reset_state({tag, "_midrst"});
                rst_n = 1'b1;
                return;
            end
            if (ifc.m2_done === 1'b1) done_at = n;
        end
        check_eq({tag, "_addr_sweep"}, addr_err, 0);
        check_eq({tag, "_done_edge"}, done_at, LATENCY);
        check_eq({tag, "_busy_fall"}, 64'(ifc.busy), 0);
    endtask

    initial begin
        ifc.start     = 1'b0;
        ifc.score_idx = '0;
        fill(0);
        #1;
        rst_n = 1'b0;
        #10;
        check_reset_state("reset");
        rst_n = 1'b1;

        run_case("unity", 1'b0, -1);
        read_scores("unity");

        fill(1);
        run_case("ramp", 1'b0, -1);
        read_scores("ramp");

        fill(2);
        run_case("neg_repulse", 1'b1, -1);
        read_scores("neg");

        // Starts straight from DONE: m2_done must drop on edge 0.
        fill(3);
        run_case("rand_from_done", 1'b0, -1);
        read_scores("rand1");

        fill(3);
        run_case("rst_mid", 1'b0, 100);
        run_case("after_rst", 1'b0, -1);
        read_scores("rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
